// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding,
// bus widths, default parameters and the latched request payload.
package sram_controller_pkg;

  localparam int unsigned SRAM_DW             = 16;
  localparam int unsigned DEF_BASE_ADDR       = 1024;
  localparam int unsigned DEF_WAIT_CYCLES     = 1;
  localparam int unsigned DEF_SRAM_AW         = 18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic        write;
    logic [31:0] data;
  } req_t;

  // Byte address to 32-bit word index relative to the SRAM window.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage responder that services each 32-bit access on a 16-bit async
// SRAM as a low then a high half-word phase, stalling the pipeline meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned WA_W  = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  logic [1:0]         state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [WA_W-1:0]    word_addr, word_next;
  req_t               req, req_next;
  logic [SRAM_DW-1:0] rd_lo;
  logic               dq_oe, dq_oe_next;
  logic [SRAM_DW-1:0] dq_out, dq_out_next;
  logic [SRAM_AW-1:0] addr_next;
  logic               we_n_next;
  logic               request;
  logic               phase_last;
  logic               in_phase_next;
  logic               half_next;
  logic               cap_lo;
  logic               cap_hi;

  assign request    = rd_en | wr_en;
  assign phase_last = (count == CNT_LAST);

  assign ready = ~((state == ST_IDLE) & request) & (state != ST_LOW) & (state != ST_HIGH);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  // Read halves are captured on the final cycle of each phase.
  assign cap_lo = (state == ST_LOW)  & phase_last & ~req.write;
  assign cap_hi = (state == ST_HIGH) & phase_last & ~req.write;

  // Next-state logic; SRAM pin values are derived from the next state so
  // they leave the flops cleanly aligned with each phase cycle.
  always_comb begin
    state_next = state;
    count_next = count;
    word_next  = word_addr;
    req_next   = req;

    case (state)
      ST_IDLE: begin
        if (request) begin
          word_next      = WA_W'(word_offset(address, 32'(BASE_ADDR)));
          req_next.write = wr_en & ~rd_en;
          req_next.data  = write_data;
          count_next     = '0;
          state_next     = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          count_next = '0;
          state_next = ST_HIGH;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          count_next = '0;
          state_next = ST_DONE;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      ST_DONE: begin
        count_next = '0;
        state_next = ST_IDLE;
      end
      default: begin
        count_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    in_phase_next = (state_next == ST_LOW) | (state_next == ST_HIGH);
    half_next     = (state_next == ST_HIGH);
    addr_next     = in_phase_next ? {word_next, half_next} : SRAM_ADDR;
    // WE_N rises on the last phase cycle so address and data hold past it.
    we_n_next     = ~(in_phase_next & req_next.write & (count_next != CNT_LAST));
    dq_oe_next    = in_phase_next & req_next.write;
    dq_out_next   = half_next ? req_next.data[31:16] : req_next.data[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      word_addr <= '0;
      req       <= '0;
      rd_lo     <= '0;
      read_data <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      state     <= state_next;
      count     <= count_next;
      word_addr <= word_next;
      req       <= req_next;
      dq_oe     <= dq_oe_next;
      dq_out    <= dq_out_next;
      SRAM_ADDR <= addr_next;
      SRAM_WE_N <= we_n_next;
      if (cap_lo) rd_lo <= SRAM_DQ;
      // Commit the whole word at once so read_data only moves when a read completes.
      if (cap_hi) read_data <= {SRAM_DQ, rd_lo};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed and randomized checks of sram_controller against a word-level
// reference memory, with a half-word SRAM model on the pins.
module tb_sram_controller;

  localparam int unsigned W1 = 1;
  localparam int unsigned W2 = 3;

  logic        clk;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] dq;
  logic [17:0] sram_addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  logic        rd_en2, wr_en2;
  logic [31:0] address2, write_data2;
  logic [31:0] read_data2;
  logic        ready2;
  wire  [15:0] dq2;
  logic [17:0] sram_addr2;
  logic        we_n2, ce_n2, oe_n2, ub_n2, lb_n2;

  logic        model_oe, model_oe2, probe_en;
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem2 [0:262143];
  logic [31:0] ref_mem [int];

  int total = 0;
  int bad   = 0;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_controller #(.WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(wr_en2), .address(address2),
    .write_data(write_data2), .read_data(read_data2), .ready(ready2),
    .SRAM_DQ(dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(we_n2), .SRAM_CE_N(ce_n2),
    .SRAM_OE_N(oe_n2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2)
  );

  // SRAM models: async read when enabled by the bench, write while WE_N is low.
  assign dq  = model_oe  ? mem1[sram_addr]  : (probe_en ? 16'h5A5A : 16'hzzzz);
  assign dq2 = model_oe2 ? mem2[sram_addr2] : 16'hzzzz;

  always @(negedge clk) if (!we_n) mem1[sram_addr] = dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
  endfunction

  // One access on dut; entered and left at 1 time unit after a rising edge.
  task automatic run_access(input bit is_wr, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
    int k;
    int p;
    int j;
    bit done;
    logic [31:0] w;
    w = ref_word(a);
    rd_en = !is_wr; wr_en = is_wr; address = a; write_data = d; model_oe = !is_wr;
    k = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        k++;
        if (k >= 2) begin
          p = (k - 2) / (W1 + 1);
          j = (k - 2) % (W1 + 1);
          chk({tag, "_addr"}, 32'(sram_addr), w * 2 + 32'(p));
          chk({tag, "_we_n"}, 32'(we_n), (is_wr && j < W1) ? 32'd0 : 32'd1);
          if (is_wr) chk({tag, "_dq"}, 32'(dq), p != 0 ? 32'(d[31:16]) : 32'(d[15:0]));
        end
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'(1 + 2 * (W1 + 1)));
    if (is_wr) ref_mem[int'(w)] = d;
    else chk({tag, "_rdata"}, read_data, ref_read(w));
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0; model_oe = 0;
  endtask

  task automatic idle_check(input int n, input logic [31:0] held, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_we_n"}, 32'(we_n), 32'd1);
      chk({tag, "_rdata"}, read_data, held);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] last;
    bit found;
    int k;
    bit is_wr;

    rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en2 = 0; wr_en2 = 0; address2 = 0; write_data2 = 0;
    model_oe = 0; model_oe2 = 0; probe_en = 0;
    for (int i = 0; i < 262144; i++) begin
      mem1[i] = 16'h0;
      mem2[i] = 16'h0;
    end

    #2 rst = 1; probe_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_dq_z", 32'(dq), 32'h5A5A);
    chk("tie_offs", {28'd0, ce_n, oe_n, ub_n, lb_n}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_dq_z", 32'(dq), 32'h5A5A);
    probe_en = 0;
    @(posedge clk); #1;

    // Tests 1-2: write then read the first word.
    run_access(1, 32'd1024, 32'hDEADBEEF, "t1_wr");
    chk("t1_mem0", 32'(mem1[0]), 32'h0000BEEF);
    chk("t1_mem1", 32'(mem1[1]), 32'h0000DEAD);
    idle_check(1, 32'd0, "t1_idle");
    run_access(0, 32'd1024, 32'h0, "t2_rd");

    // Test 3: back-to-back write/read with no gap; test 4: read held through DONE.
    run_access(1, 32'd1028, 32'h12345678, "t3_wr");
    run_access(0, 32'd1028, 32'h0, "t3_rd");
    idle_check(3, 32'h12345678, "t4_idle");

    // Address below the window wraps to the top of the SRAM.
    run_access(1, 32'd1020, 32'hA1B2C3D4, "wrap_wr");
    chk("wrap_mem", {mem1[262143], mem1[262142]}, 32'hA1B2C3D4);
    run_access(0, 32'd1020, 32'h0, "wrap_rd");

    // Test 5: reset while the high phase of a write is driving.
    rd_en = 0; wr_en = 1; address = 32'd1032; write_data = 32'hCAFEF00D;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (sram_addr == 18'd4 && we_n && !ready) found = 1;
    end
    chk("t5_reach_low_end", 32'(found), 32'd1);
    @(posedge clk); #1;
    chk("t5_high_we_n", 32'(we_n), 32'd0);
    chk("t5_high_addr", 32'(sram_addr), 32'd5);
    chk("t5_high_dq", 32'(dq), 32'h0000CAFE);
    rst = 1; wr_en = 0; probe_en = 1;
    #1;
    chk("t5_we_n", 32'(we_n), 32'd1);
    chk("t5_dq_z", 32'(dq), 32'h5A5A);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_addr", 32'(sram_addr), 32'd0);
    chk("t5_rdata", read_data, 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t5_post_ready", 32'(ready), 32'd1);
    probe_en = 0;
    chk("t5_mem_lo", 32'(mem1[4]), 32'h0000F00D);
    chk("t5_mem_hi", 32'(mem1[5]), 32'h00000000);
    ref_mem[2] = 32'h0000F00D;
    @(posedge clk); #1;
    run_access(0, 32'd1032, 32'h0, "t5_rd");

    // Randomized accesses over a small window, checked against ref_mem.
    last = read_data;
    for (int i = 0; i < 24; i++) begin
      is_wr = 1'($urandom_range(0, 1));
      a = 32'd1024 + 32'($urandom_range(0, 31)) * 4;
      d = $urandom;
      run_access(is_wr, a, d, $sformatf("rnd%0d", i));
      if (!is_wr) last = read_data;
      idle_check($urandom_range(0, 2), last, $sformatf("rnd%0d_gap", i));
    end

    // Test 6: WAIT_CYCLES=3; each half changes just before its last phase cycle.
    mem2[0] = 16'h1111; mem2[1] = 16'h2222;
    rd_en2 = 1; address2 = 32'd1024; model_oe2 = 1;
    k = 0; found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (ready2) found = 1;
      else begin
        k++;
        if (k >= 2 && (k - 2) % (W2 + 1) == W2) begin
          if ((k - 2) / (W2 + 1) == 0) mem2[0] = 16'hAAAA;
          else mem2[1] = 16'hBBBB;
        end
      end
    end
    chk("t6_done", 32'(found), 32'd1);
    chk("t6_latency", 32'(k), 32'(1 + 2 * (W2 + 1)));
    chk("t6_rdata", read_data2, 32'hBBBBAAAA);
    @(posedge clk); #1;
    rd_en2 = 0; model_oe2 = 0;
    @(negedge clk);
    chk("t6_idle_ready", 32'(ready2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
